// File: rtl/can_mac_pkg.sv
// rtl/can_mac_pkg.sv - shared CAN MAC types, field widths and CRC-15 step function
package can_mac_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ARB,
        ST_CTRL,
        ST_DATA,
        ST_CRC,
        ST_CRC_DEL,
        ST_ACK,
        ST_ACK_DEL,
        ST_EOF,
        ST_WAIT_IDLE
    } can_rx_state_t;

    localparam logic [14:0] CAN_CRC15_POLY   = 15'h4599;
    localparam int          ID_W             = 11;
    localparam int          DLC_W            = 4;
    localparam int          CRC_W            = 15;
    localparam int          EOF_BITS_DEFAULT = 7;

    // One serial CRC-15 step, MSB-first.
    function automatic logic [CRC_W-1:0] crc15_step(input logic [CRC_W-1:0] crc,
                                                    input logic             b);
        return {crc[CRC_W-2:0], 1'b0} ^ ((b ^ crc[CRC_W-1]) ? CAN_CRC15_POLY : '0);
    endfunction

endpackage

// File: rtl/can_crc15.sv
// rtl/can_crc15.sv - serial CRC-15 register
// Ports: clock, reset (sync, active-high), clear (zero the register),
//        enable (absorb bit_in), bit_in, crc (current remainder).
// clear together with enable seeds the register from zero with bit_in, so a
// frame may start on the very strobe that would otherwise only clear it.
module can_crc15
    import can_mac_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic             bit_in,
    output logic [CRC_W-1:0] crc
);

    logic [CRC_W-1:0] crc_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            crc_q <= '0;
        end else if (clear) begin
            crc_q <= enable ? crc15_step('0, bit_in) : '0;
        end else if (enable) begin
            crc_q <= crc15_step(crc_q, bit_in);
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/can_rx_frame_decoder.sv
// rtl/can_rx_frame_decoder.sv - CAN 2.0A receive frame decoder
// Ports: clock, reset (sync, active-high); bit_valid/bit_val destuffed bit
//        stream (0 = dominant); rx_id/rx_rtr/rx_dlc/rx_data decoded fields;
//        frame_valid, crc_error, form_error one-cycle pulses; ack_drive
//        requests a dominant ACK slot; busy is high outside IDLE.
module can_rx_frame_decoder
    import can_mac_pkg::*;
#(
    parameter int MAX_DATA_BYTES = 8,
    parameter int EOF_BITS       = EOF_BITS_DEFAULT,
    parameter int IDLE_BITS      = 7
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             bit_valid,
    input  logic             bit_val,
    output logic [ID_W-1:0]  rx_id,
    output logic             rx_rtr,
    output logic [DLC_W-1:0] rx_dlc,
    output logic [63:0]      rx_data,
    output logic             frame_valid,
    output logic             crc_error,
    output logic             form_error,
    output logic             ack_drive,
    output logic             busy
);

    can_rx_state_t    state_q, state_d;
    logic [6:0]       cnt_q, cnt_d;
    logic [ID_W-1:0]  rx_id_q, rx_id_d;
    logic             rx_rtr_q, rx_rtr_d;
    logic [DLC_W-1:0] rx_dlc_q, rx_dlc_d;
    logic [63:0]      rx_data_q, rx_data_d;
    logic [CRC_W-1:0] rx_crc_q, rx_crc_d;
    logic             crc_ok_q, crc_ok_d;
    logic [3:0]       nbytes_q, nbytes_d;
    logic             frame_valid_q, frame_valid_d;
    logic             crc_error_q, crc_error_d;
    logic             form_error_q, form_error_d;

    logic [CRC_W-1:0] crc_val;
    logic             crc_clear;
    logic             crc_en;
    logic [DLC_W-1:0] dlc_full;
    logic [3:0]       n_next;
    logic [5:0]       data_idx;
    logic [6:0]       data_last;

    can_crc15 u_crc (
        .clock  (clock),
        .reset  (reset),
        .clear  (crc_clear),
        .enable (crc_en),
        .bit_in (bit_val),
        .crc    (crc_val)
    );

    // DLC as it will read once the current (last) DLC bit is shifted in.
    assign dlc_full  = {rx_dlc_q[DLC_W-2:0], bit_val};
    assign n_next    = rx_rtr_q ? 4'd0 :
                       ((int'(dlc_full) > MAX_DATA_BYTES) ? 4'(MAX_DATA_BYTES) : dlc_full);
    // Byte0 arrives first and lands at the top of rx_data.
    assign data_idx  = 6'd63 - cnt_q[5:0];
    assign data_last = {nbytes_q, 3'b000} - 7'd1;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        rx_id_d       = rx_id_q;
        rx_rtr_d      = rx_rtr_q;
        rx_dlc_d      = rx_dlc_q;
        rx_data_d     = rx_data_q;
        rx_crc_d      = rx_crc_q;
        crc_ok_d      = crc_ok_q;
        nbytes_d      = nbytes_q;
        frame_valid_d = 1'b0;
        crc_error_d   = 1'b0;
        form_error_d  = 1'b0;
        crc_clear     = (state_q == ST_IDLE);
        crc_en        = 1'b0;

        if (bit_valid) begin
            cnt_d = cnt_q + 7'd1;
            unique case (state_q)
                ST_IDLE: begin
                    cnt_d = '0;
                    if (!bit_val) begin
                        state_d   = ST_ARB;
                        crc_en    = 1'b1;
                        rx_id_d   = '0;
                        rx_rtr_d  = 1'b0;
                        rx_dlc_d  = '0;
                        rx_data_d = '0;
                        rx_crc_d  = '0;
                        crc_ok_d  = 1'b0;
                        nbytes_d  = '0;
                    end
                end
                ST_ARB: begin
                    crc_en = 1'b1;
                    if (cnt_q < 7'd11) begin
                        rx_id_d = {rx_id_q[ID_W-2:0], bit_val};
                    end else begin
                        rx_rtr_d = bit_val;
                        state_d  = ST_CTRL;
                        cnt_d    = '0;
                    end
                end
                ST_CTRL: begin
                    crc_en = 1'b1;
                    if (cnt_q == 7'd0 && bit_val) begin
                        form_error_d = 1'b1;
                        state_d      = ST_WAIT_IDLE;
                        cnt_d        = '0;
                    end else if (cnt_q >= 7'd2) begin
                        rx_dlc_d = dlc_full;
                        if (cnt_q == 7'd5) begin
                            nbytes_d = n_next;
                            state_d  = (n_next != 4'd0) ? ST_DATA : ST_CRC;
                            cnt_d    = '0;
                        end
                    end
                end
                ST_DATA: begin
                    crc_en              = 1'b1;
                    rx_data_d[data_idx] = bit_val;
                    if (cnt_q == data_last) begin
                        state_d = ST_CRC;
                        cnt_d   = '0;
                    end
                end
                ST_CRC: begin
                    rx_crc_d = {rx_crc_q[CRC_W-2:0], bit_val};
                    if (cnt_q == 7'd14) begin
                        crc_ok_d = ({rx_crc_q[CRC_W-2:0], bit_val} == crc_val);
                        state_d  = ST_CRC_DEL;
                        cnt_d    = '0;
                    end
                end
                ST_CRC_DEL: begin
                    cnt_d = '0;
                    if (!bit_val) begin
                        form_error_d = 1'b1;
                        state_d      = ST_WAIT_IDLE;
                    end else begin
                        state_d = ST_ACK;
                    end
                end
                ST_ACK: begin
                    cnt_d   = '0;
                    state_d = ST_ACK_DEL;
                end
                ST_ACK_DEL: begin
                    cnt_d = '0;
                    if (!bit_val) begin
                        form_error_d = 1'b1;
                        state_d      = ST_WAIT_IDLE;
                    end else if (!crc_ok_q) begin
                        crc_error_d = 1'b1;
                        state_d     = ST_WAIT_IDLE;
                    end else begin
                        state_d = ST_EOF;
                    end
                end
                ST_EOF: begin
                    if (!bit_val) begin
                        form_error_d = 1'b1;
                        state_d      = ST_WAIT_IDLE;
                        cnt_d        = '0;
                    end else if (cnt_q == 7'(EOF_BITS - 1)) begin
                        frame_valid_d = 1'b1;
                        state_d       = ST_IDLE;
                        cnt_d         = '0;
                    end
                end
                ST_WAIT_IDLE: begin
                    if (!bit_val) begin
                        cnt_d = '0;
                    end else if (cnt_q == 7'(IDLE_BITS - 1)) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            rx_id_q       <= '0;
            rx_rtr_q      <= 1'b0;
            rx_dlc_q      <= '0;
            rx_data_q     <= '0;
            rx_crc_q      <= '0;
            crc_ok_q      <= 1'b0;
            nbytes_q      <= '0;
            frame_valid_q <= 1'b0;
            crc_error_q   <= 1'b0;
            form_error_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rx_id_q       <= rx_id_d;
            rx_rtr_q      <= rx_rtr_d;
            rx_dlc_q      <= rx_dlc_d;
            rx_data_q     <= rx_data_d;
            rx_crc_q      <= rx_crc_d;
            crc_ok_q      <= crc_ok_d;
            nbytes_q      <= nbytes_d;
            frame_valid_q <= frame_valid_d;
            crc_error_q   <= crc_error_d;
            form_error_q  <= form_error_d;
        end
    end

    assign rx_id       = rx_id_q;
    assign rx_rtr      = rx_rtr_q;
    assign rx_dlc      = rx_dlc_q;
    assign rx_data     = rx_data_q;
    assign frame_valid = frame_valid_q;
    assign crc_error   = crc_error_q;
    assign form_error  = form_error_q;
    assign ack_drive   = (state_q == ST_ACK) && crc_ok_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: doc/can_rx_frame_decoder.md
Name: can_rx_frame_decoder

Overview:
Receive-side CAN 2.0A MAC frame decoder. It consumes the destuffed bit stream, one bit per strobe, from the bit-timing/destuff stage. It parses SOF, arbitration, control, data, CRC, delimiters, ACK and EOF, and recomputes CRC-15 over SOF..data to check it against the received CRC field. It presents the decoded ID, RTR, DLC and data with a valid pulse. It also flags CRC and form errors and requests the dominant ACK bit from the transmit path.

Parameters:
MAX_DATA_BYTES, 8, payload capacity in bytes; DLC values above this are clamped to it.
EOF_BITS, 7, number of recessive EOF bits.
IDLE_BITS, 7, consecutive recessive bits required to leave WAIT_IDLE.

Ports:
clock  in  1  system clock.
reset  in  1  synchronous, active-high reset.
bit_valid  in  1  one-cycle strobe; bit_val is sampled only on cycles where this is high.
bit_val  in  1  destuffed bus bit; 0 = dominant, 1 = recessive.
rx_id  out  11  received identifier.
rx_rtr  out  1  received RTR bit.
rx_dlc  out  4  received DLC, raw and unclamped.
rx_data  out  64  payload; byte0 at [63:56]; unreceived bytes are 0.
frame_valid  out  1  one-cycle pulse; rx_* fields are valid on this pulse.
crc_error  out  1  one-cycle pulse on CRC mismatch.
form_error  out  1  one-cycle pulse on a fixed-form violation.
ack_drive  out  1  high for the entire ACK state when the CRC matched.
busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: state=IDLE; all outputs 0; CRC register 0; bit counter 0. Reset asserted mid-frame aborts the frame with no pulses.
- All state and outputs are registered and update only on clock edges where bit_valid=1, except that pulses deassert on the next clock edge.
- Pulse latency: each pulse asserts in the cycle after the strobe that completes its condition, for exactly one cycle.
- Bit order: all fields are received MSB first; data is received byte0 first.
- CRC-15:
  - Update per bit: crc <= {crc[13:0],1'b0} ^ ((bit ^ crc[14]) ? 15'h4599 : 15'h0).
  - Cleared in IDLE.
  - Updated on every bit from SOF through the last data bit.
  - Held constant from the first CRC-field bit onward.
- States and transitions:
  - IDLE: a dominant bit is SOF; feed it to the CRC and go to ARB. A recessive bit stays in IDLE.
  - ARB: 12 bits (ID[10:0], then RTR), then go to CTRL.
  - CTRL: 6 bits (IDE, r0, DLC[3:0]).
    - IDE=1 (extended frame, unsupported): form_error, go to WAIT_IDLE.
    - r0 is ignored.
    - Set n = min(DLC, MAX_DATA_BYTES), or n = 0 if RTR=1.
    - After the last DLC bit: go to DATA if n>0, else go to CRC.
  - DATA: 8*n bits, then go to CRC.
  - CRC: 15 bits shifted into rx_crc. After the 15th bit, latch crc_ok = (rx_crc == crc). Go to CRC_DEL.
  - CRC_DEL: a dominant bit gives form_error and goes to WAIT_IDLE; otherwise go to ACK.
  - ACK: 1 bit; any value is accepted. ack_drive = crc_ok for the whole state. Go to ACK_DEL.
  - ACK_DEL:
    - Dominant bit: form_error, go to WAIT_IDLE.
    - Recessive bit with !crc_ok: crc_error, go to WAIT_IDLE.
    - Recessive bit with crc_ok: go to EOF.
  - EOF: EOF_BITS bits.
    - Any dominant bit gives form_error and goes to WAIT_IDLE.
    - After the last recessive bit: frame_valid, go to IDLE.
  - WAIT_IDLE: count consecutive recessive bits; a dominant bit resets the count. At IDLE_BITS go to IDLE.
- rx_* fields are captured progressively as bits arrive and are zeroed at SOF. They hold their values after frame_valid until the next SOF.
- Simultaneous conditions: at most one of crc_error, form_error or frame_valid pulses per frame. A form error on CRC_DEL takes precedence over the CRC result (no crc_error).
- bit_valid held continuously high is legal: one bit is processed per clock.

Decomposition:
- Package can_mac_pkg holds:
  - state enum can_rx_state_t;
  - CAN_CRC15_POLY = 15'h4599;
  - field widths ID_W=11, DLC_W=4, CRC_W=15;
  - EOF_BITS_DEFAULT.
- Sub-module can_crc15: serial CRC-15 register with ports clock, reset, clear, enable, bit_in, crc[14:0]. It is instantiated once; the decoder owns clear and enable.

Test Plan:
- Data frame: SOF, ID=11'h123, RTR=0, IDE=0, r0=0, DLC=4, data 32'hDEADBEEF, CRC from bench model, recessive delimiters, dominant ACK, 7 recessive EOF bits -> ack_drive=1 during ACK; one frame_valid with rx_id=0x123, rx_dlc=4, rx_data=64'hDEADBEEF_00000000; no error pulses.
- Same frame with CRC bit 0 flipped -> ack_drive=0; crc_error pulses one cycle after the ACK_DEL strobe; no frame_valid; decoder returns to IDLE after 7 recessive bits.
- Remote frame: ID=11'h7FF, RTR=1, DLC=8, correct CRC -> DATA state skipped; frame_valid with rx_rtr=1, rx_dlc=8, rx_data=0.
- DLC=15 with 8 data bytes 0x01..0x08 -> exactly 64 data bits consumed; rx_dlc=15; rx_data=64'h0102030405060708; frame_valid.
- Dominant bit at EOF bit 3 of an otherwise good frame -> form_error; no frame_valid. Separately, dominant CRC delimiter -> form_error and no crc_error.
- reset asserted for 1 cycle during DATA, then a full valid frame -> all outputs 0 after reset; the second frame decodes correctly; busy=0 between frames.
